// File: rtl/noc_traffic_node_pkg.sv
// noc_traffic_node_pkg: flit layout constants, state types and helpers for the traffic node
package noc_traffic_node_pkg;
  localparam int NOC_DATA_W = 32;
  localparam int NOC_ID_X_W = 4;
  localparam int NOC_ID_Y_W = 4;
  localparam int NOC_TEST_SEQ_W = 16;
  localparam logic [3:0] NOC_HEAD_H = 4'hA;
  localparam logic [3:0] NOC_HEAD_E = 4'h5;
  localparam logic [3:0] NOC_TAIL_H = 4'hC;
  localparam logic [3:0] NOC_TAIL_E = 4'h3;
  localparam int MARK_H_LSB = 28;
  localparam int MARK_E_LSB = 0;
  localparam int DEST_LSB = 12;
  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_GAP, TX_DONE} tx_state_t;
  typedef enum logic {RX_HEAD, RX_BODY} rx_state_t;
  // Control flit: {H, src x, src y, dst x, dst y, type, order, len, E}
  function automatic logic [NOC_DATA_W-1:0] mk_ctl(input logic [3:0] h, input logic [3:0] e,
                                                   input logic [NOC_ID_X_W-1:0] x, input logic [NOC_ID_Y_W-1:0] y,
                                                   input logic [NOC_ID_X_W-1:0] dx, input logic [NOC_ID_Y_W-1:0] dy);
    return {h, x, y, dx, dy, 2'b00, 2'b00, 4'h0, e};
  endfunction
  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/noc_traffic_checker.sv
// noc_traffic_checker: receive path that validates packet format and length and counts packets/errors
module noc_traffic_checker
  import noc_traffic_node_pkg::*;
#(
  parameter logic [NOC_ID_X_W-1:0] X_ID = '0,
  parameter logic [NOC_ID_Y_W-1:0] Y_ID = '0,
  parameter int PKT_BODY_FLITS = 1
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [NOC_DATA_W-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic [15:0]           rx_pkt_cnt,
  output logic [15:0]           rx_err_cnt
);
  rx_state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_bad, r_ready;
  logic w_hs, w_hd, w_body, w_head_ok, w_tail_ok, w_body_ok;
  logic w_close_old, w_close_one, w_close_tail, w_drop, w_unused;
  logic [1:0] w_pkt_inc, w_err_inc;
  assign receive_ready = r_ready;
  assign w_hs = receive_valid && r_ready;
  assign w_hd = w_hs && receive_is_header;
  assign w_body = w_hs && r_state == RX_BODY && !receive_is_header && !receive_is_tail;
  assign w_head_ok = receive_flit[MARK_H_LSB +: 4] == NOC_HEAD_H && receive_flit[MARK_E_LSB +: 4] == NOC_HEAD_E &&
                     receive_flit[DEST_LSB +: NOC_ID_X_W + NOC_ID_Y_W] == {X_ID, Y_ID};
  assign w_tail_ok = receive_flit[MARK_H_LSB +: 4] == NOC_TAIL_H && receive_flit[MARK_E_LSB +: 4] == NOC_TAIL_E &&
                     int'(r_cnt) == PKT_BODY_FLITS;
  assign w_body_ok = receive_flit[15:0] == {8'h00, r_cnt};
  assign w_close_old = w_hd && r_state == RX_BODY;
  assign w_close_one = w_hd && receive_is_tail;
  assign w_close_tail = w_hs && receive_is_tail && !receive_is_header && r_state == RX_BODY;
  assign w_drop = w_hs && !receive_is_header && r_state == RX_HEAD;
  assign w_pkt_inc = {1'b0, w_close_old} + {1'b0, w_close_one} + {1'b0, w_close_tail};
  assign w_err_inc = {1'b0, w_close_old} + {1'b0, w_close_one} + {1'b0, w_close_tail && (r_bad || !w_tail_ok)} + {1'b0, w_drop};
  assign w_unused = ^receive_flit[27:20];
  // Packet framing state register
  always_ff @(posedge noc_clk or posedge noc_rst)
    if (noc_rst) r_state <= RX_HEAD;
    else r_state <= w_next;
  // Header opens a packet unless it is also a tail; a tail closes an open packet
  always_comb begin
    w_next = r_state;
    if (w_hd) w_next = receive_is_tail ? RX_HEAD : RX_BODY;
    else if (w_close_tail) w_next = RX_HEAD;
  end
  // Body index, per-packet error flag, ready and saturating counters
  always_ff @(posedge noc_clk or posedge noc_rst)
    if (noc_rst) begin
      r_ready <= 1'b0;
      r_cnt <= '0;
      r_bad <= 1'b0;
      rx_pkt_cnt <= '0;
      rx_err_cnt <= '0;
    end else begin
      r_ready <= 1'b1;
      r_cnt <= w_hd ? '0 : (w_body && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
      r_bad <= w_hd ? !w_head_ok : (w_body && !w_body_ok) ? 1'b1 : r_bad;
      rx_pkt_cnt <= sat_add(rx_pkt_cnt, w_pkt_inc);
      rx_err_cnt <= sat_add(rx_err_cnt, w_err_inc);
    end
endmodule

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: wormhole packet generator with an attached receive-side checker
module noc_traffic_node
  import noc_traffic_node_pkg::*;
#(
  parameter logic [NOC_ID_X_W-1:0] X_ID = '0,
  parameter logic [NOC_ID_Y_W-1:0] Y_ID = '0,
  parameter logic [NOC_ID_X_W-1:0] DEST_X_ID = '0,
  parameter logic [NOC_ID_Y_W-1:0] DEST_Y_ID = '0,
  parameter int PKT_BODY_FLITS = 1,
  parameter int PKT_COUNT = 51,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  send_start,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [NOC_DATA_W-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [NOC_DATA_W-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic [15:0]           tx_pkt_cnt,
  output logic [15:0]           rx_pkt_cnt,
  output logic [15:0]           rx_err_cnt,
  output logic                  done
);
  tx_state_t r_state, w_next;
  logic [NOC_TEST_SEQ_W-1:0] r_pkt;
  logic [15:0] r_tx_cnt;
  logic [7:0] r_body, r_gap;
  logic w_hs, w_last;
  assign w_hs = sender_valid && sender_ready;
  assign w_last = int'(r_pkt) == PKT_COUNT - 1;
  assign tx_pkt_cnt = r_tx_cnt;
  assign done = r_state == TX_DONE;
  // Transmit state register
  always_ff @(posedge noc_clk or posedge noc_rst)
    if (noc_rst) r_state <= TX_IDLE;
    else r_state <= w_next;
  // Flit/flag outputs are pure functions of state so they hold while ready is low
  always_comb begin
    w_next = r_state;
    sender_valid = 1'b0;
    sender_flit = '0;
    sender_is_header = 1'b0;
    sender_is_tail = 1'b0;
    case (r_state)
      TX_IDLE: w_next = send_start ? TX_HEAD : TX_IDLE;
      TX_HEAD: begin
        sender_valid = 1'b1;
        sender_is_header = 1'b1;
        sender_flit = mk_ctl(NOC_HEAD_H, NOC_HEAD_E, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID);
        if (sender_ready) w_next = PKT_BODY_FLITS == 0 ? TX_TAIL : TX_BODY;
      end
      TX_BODY: begin
        sender_valid = 1'b1;
        sender_flit = {r_pkt, 8'h00, r_body};
        if (sender_ready && int'(r_body) == PKT_BODY_FLITS - 1) w_next = TX_TAIL;
      end
      TX_TAIL: begin
        sender_valid = 1'b1;
        sender_is_tail = 1'b1;
        sender_flit = mk_ctl(NOC_TAIL_H, NOC_TAIL_E, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID);
        if (sender_ready) w_next = w_last ? TX_DONE : GAP_CYCLES == 0 ? TX_HEAD : TX_GAP;
      end
      TX_GAP: w_next = int'(r_gap) == GAP_CYCLES - 1 ? TX_HEAD : TX_GAP;
      default: w_next = r_state;
    endcase
  end
  // Body index, gap timer, packet sequence and transmitted-packet counter
  always_ff @(posedge noc_clk or posedge noc_rst)
    if (noc_rst) begin
      r_pkt <= '0;
      r_body <= '0;
      r_gap <= '0;
      r_tx_cnt <= '0;
    end else begin
      r_body <= r_state == TX_BODY ? r_body + {7'b0, w_hs} : '0;
      r_gap <= r_state == TX_GAP ? r_gap + 8'd1 : '0;
      r_pkt <= r_pkt + {15'b0, r_state == TX_TAIL && w_hs};
      r_tx_cnt <= (r_state == TX_TAIL && w_hs) ? sat_add(r_tx_cnt, 2'd1) : r_tx_cnt;
    end
  noc_traffic_checker #(
    .X_ID(X_ID),
    .Y_ID(Y_ID),
    .PKT_BODY_FLITS(PKT_BODY_FLITS)
  ) u_checker (
    .noc_clk(noc_clk),
    .noc_rst(noc_rst),
    .receive_valid(receive_valid),
    .receive_ready(receive_ready),
    .receive_flit(receive_flit),
    .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .rx_pkt_cnt(rx_pkt_cnt),
    .rx_err_cnt(rx_err_cnt)
  );
endmodule

// File: tb/tb_noc_traffic_node.sv
// tb_noc_traffic_node: loopback, random backpressure, gap, reset and injected-error checks
module tb_noc_traffic_node;
  import noc_traffic_node_pkg::*;
  typedef struct packed {logic [31:0] f; logic h; logic t;} flit_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_start = 1'b0, a_sr = 1'b0, inj = 1'b0, iv = 1'b0, ih = 1'b0, it = 1'b0;
  logic a_sv, a_sh, a_st, a_rr, a_done;
  logic [31:0] a_sf, ifl = '0;
  logic [15:0] a_tx, a_rx, a_err;
  logic b_start = 1'b0, b_sr = 1'b0;
  logic b_sv, b_sh, b_st, b_rr, b_done;
  logic [31:0] b_sf;
  logic [15:0] b_tx, b_rx, b_err;

  noc_traffic_node #(.X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd1), .DEST_Y_ID(4'd2),
                     .PKT_BODY_FLITS(3), .PKT_COUNT(4), .GAP_CYCLES(0)) u_a (
    .noc_clk(clk), .noc_rst(rst), .send_start(a_start),
    .sender_valid(a_sv), .sender_ready(a_sr), .sender_flit(a_sf),
    .sender_is_header(a_sh), .sender_is_tail(a_st),
    .receive_valid(inj ? iv : a_sv && a_sr), .receive_ready(a_rr),
    .receive_flit(inj ? ifl : a_sf), .receive_is_header(inj ? ih : a_sh),
    .receive_is_tail(inj ? it : a_st),
    .tx_pkt_cnt(a_tx), .rx_pkt_cnt(a_rx), .rx_err_cnt(a_err), .done(a_done));

  noc_traffic_node #(.X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd1), .DEST_Y_ID(4'd2),
                     .PKT_BODY_FLITS(0), .PKT_COUNT(3), .GAP_CYCLES(5)) u_b (
    .noc_clk(clk), .noc_rst(rst), .send_start(b_start),
    .sender_valid(b_sv), .sender_ready(b_sr), .sender_flit(b_sf),
    .sender_is_header(b_sh), .sender_is_tail(b_st),
    .receive_valid(b_sv && b_sr), .receive_ready(b_rr),
    .receive_flit(b_sf), .receive_is_header(b_sh), .receive_is_tail(b_st),
    .tx_pkt_cnt(b_tx), .rx_pkt_cnt(b_rx), .rx_err_cnt(b_err), .done(b_done));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec flit sequence: flit k belongs to packet k/(body+2) at position k%(body+2)
  function automatic logic [31:0] ctl(input logic [3:0] h, input logic [3:0] e, input logic [3:0] dx);
    return {h, 4'd1, 4'd2, dx, 4'd2, 8'h00, e};
  endfunction

  function automatic flit_t exp_flit(input int body, input int k);
    int p, pos;
    p = k / (body + 2);
    pos = k % (body + 2);
    if (pos == 0) return '{ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 1'b1, 1'b0};
    if (pos == body + 1) return '{ctl(NOC_TAIL_H, NOC_TAIL_E, 4'd1), 1'b0, 1'b1};
    return '{{p[15:0], 16'(pos - 1)}, 1'b0, 1'b0};
  endfunction

  int ka = 0, kb = 0, b_idle = -1;
  logic a_hold = 1'b0;
  logic [33:0] a_prev = '0;
  flit_t fa, fb;

  // Node A monitor: every handshake against the reference sequence, plus hold-under-backpressure
  always @(negedge clk) begin
    if (rst) begin
      ka = 0;
      a_hold = 1'b0;
    end else if (!inj) begin
      if (a_hold) begin
        chk("a_valid_hold", a_sv, 1);
        chk("a_stable", {a_sf, a_sh, a_st}, a_prev);
      end
      if (a_sv && a_sr) begin
        fa = exp_flit(3, ka);
        chk("a_flit", a_sf, fa.f);
        chk("a_flags", {a_sh, a_st}, {fa.h, fa.t});
        ka++;
      end
      a_hold = a_sv && !a_sr;
      a_prev = {a_sf, a_sh, a_st};
    end
  end

  // Node B monitor: reference sequence and idle cycles between tail and next header
  always @(negedge clk) begin
    if (rst) begin
      kb = 0;
      b_idle = -1;
    end else if (b_sv && b_sr) begin
      fb = exp_flit(0, kb);
      chk("b_flit", b_sf, fb.f);
      chk("b_flags", {b_sh, b_st}, {fb.h, fb.t});
      if (b_sh && b_idle >= 0) chk("b_gap", b_idle, 5);
      b_idle = b_st ? 0 : -1;
      kb++;
    end else if (!b_sv && b_idle >= 0) b_idle++;
  end

  task automatic pulse_reset;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f, input logic h, input logic t);
    iv = 1'b1;
    ifl = f;
    ih = h;
    it = t;
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  task automatic inj_pkt(input logic [31:0] hd, input int nb, input logic [31:0] tl);
    send(hd, 1'b1, 1'b0);
    for (int i = 0; i < nb; i++) send({16'd0, 16'(i)}, 1'b0, 1'b0);
    send(tl, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #1;
    chk("rst_valid", a_sv, 0);
    chk("rst_flit", a_sf, 0);
    chk("rst_flags", {a_sh, a_st}, 0);
    chk("rst_rready", a_rr, 0);
    chk("rst_cnts", {a_tx, a_rx, a_err}, 0);
    chk("rst_done", a_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rready_before_edge", a_rr, 0);
    @(posedge clk);
    #1 chk("rready_rise", a_rr, 1);
    // Loopback, ready held high: 20 back-to-back flits
    a_sr = 1'b1;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    chk("a_first_header", {a_sv, a_sh}, 2'b11);
    n = 0;
    while (a_sv && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("a_run_len", n, 20);
    chk("a_done", a_done, 1);
    chk("a_counts", {a_tx, a_rx, a_err}, {16'd4, 16'd4, 16'd0});
    chk("a_flits_seen", ka, 20);
    // Random backpressure
    pulse_reset();
    chk("a_cnt_cleared", {a_tx, a_rx, a_err, 15'd0, a_done}, 0);
    a_start = 1'b1;
    a_sr = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1 a_start = 1'b0;
    for (int c = 0; c < 600 && !a_done; c++) begin
      a_sr = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("rand_done", a_done, 1);
    chk("rand_counts", {a_tx, a_rx, a_err}, {16'd4, 16'd4, 16'd0});
    chk("rand_flits_seen", ka, 20);
    // Reset in the middle of packet 1's body, then restart from p=0
    pulse_reset();
    a_sr = 1'b1;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    for (int c = 0; c < 50 && !(a_tx == 16'd1 && a_sv && !a_sh && !a_st); c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_body_reached", a_tx == 16'd1 && a_sv && !a_sh && !a_st, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_sv, 0);
    chk("mid_rst_flit", {a_sf, a_sh, a_st}, 0);
    chk("mid_rst_cnts", {a_tx, a_rx, a_err}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
    chk("restart_header", {a_sv, a_sh, a_sf}, {2'b11, ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1)});
    for (int c = 0; c < 100 && !a_done; c++) begin
      @(posedge clk);
      #1;
    end
    chk("restart_counts", {a_tx, a_rx, a_err, 15'd0, a_done}, {16'd4, 16'd4, 16'd0, 16'd1});
    chk("restart_flits_seen", ka, 20);
    // Injected malformed traffic on node A's receive port
    inj = 1'b1;
    pulse_reset();
    inj_pkt(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 2, ctl(NOC_TAIL_H, NOC_TAIL_E, 4'd1));
    chk("inj_short", {a_rx, a_err}, {16'd1, 16'd1});
    inj_pkt(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd3), 3, ctl(NOC_TAIL_H, NOC_TAIL_E, 4'd1));
    chk("inj_wrong_dest", {a_rx, a_err}, {16'd2, 16'd2});
    send(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 1'b1, 1'b0);
    send(32'd0, 1'b0, 1'b0);
    chk("inj_open", {a_rx, a_err}, {16'd2, 16'd2});
    inj_pkt(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 3, ctl(4'hF, NOC_TAIL_E, 4'd1));
    chk("inj_four", {a_rx, a_err}, {16'd4, 16'd4});
    send(32'd0, 1'b0, 1'b0);
    chk("inj_stray_body", {a_rx, a_err}, {16'd4, 16'd5});
    send(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 1'b1, 1'b1);
    chk("inj_head_tail", {a_rx, a_err}, {16'd5, 16'd6});
    inj_pkt(ctl(NOC_HEAD_H, NOC_HEAD_E, 4'd1), 3, ctl(NOC_TAIL_H, NOC_TAIL_E, 4'd1));
    chk("inj_good", {a_rx, a_err}, {16'd6, 16'd6});
    send({16'd0, 16'd0}, 1'b0, 1'b1);
    chk("inj_tail_in_head", {a_rx, a_err}, {16'd6, 16'd7});
    inj = 1'b0;
    // Node B: zero-body packets with a five-cycle gap
    b_sr = 1'b1;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int c = 0; c < 200 && !b_done; c++) begin
      @(posedge clk);
      #1;
    end
    chk("b_done", b_done, 1);
    chk("b_counts", {b_tx, b_rx, b_err}, {16'd3, 16'd3, 16'd0});
    chk("b_flits_seen", kb, 6);
    repeat (3) @(posedge clk);
    #1 chk("b_done_sticky", {b_done, b_sv}, 2'b10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
